vga_timing_gen: RTL and testbench

//  Parametrised VGA/DVI raster timing generator, single clk_pixel domain; feeds vga2dvid in the board tops.

---
 rtl/video_timing_pkg.sv | 24 ++
 rtl/video_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster arithmetic for the VGA/DVI timing generator: line/frame totals,
// sync-window compares and counter width checks.
package video_timing_pkg;

    function automatic int h_total(input int res, input int front_porch, input int pulse, input int back_porch);
        return res + front_porch + pulse + back_porch;
    endfunction

    function automatic int v_total(input int res, input int front_porch, input int pulse, input int back_porch);
        return res + front_porch + pulse + back_porch;
    endfunction

    // True while pos lies in the half-open window [start, start+len).
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

    function automatic bit fits_width(input int bits, input int max_value);
        if (bits >= 31)
            return 1'b1;
        return max_value < (1 << bits);
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Clock-enabled shift register with a programmable reset word; DEPTH 0 is a plain wire.
module video_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++)
                        stage[i] <= RESET_VALUE;
                end else if (ce) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++)
                        stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: master counters give the fetch position; controls and colour
// appear on the vga_* outputs C_fetch_lead cycles later.
module vga_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   C_resolution_x      = 1024,
    parameter int   C_hsync_front_porch = 16,
    parameter int   C_hsync_pulse       = 96,
    parameter int   C_hsync_back_porch  = 44,
    parameter int   C_resolution_y      = 768,
    parameter int   C_vsync_front_porch = 10,
    parameter int   C_vsync_pulse       = 2,
    parameter int   C_vsync_back_porch  = 31,
    parameter int   C_bits_x            = 11,
    parameter int   C_bits_y            = 11,
    parameter logic C_hsync_polarity    = 1'b0,
    parameter logic C_vsync_polarity    = 1'b0,
    parameter int   C_fetch_lead        = 4,
    parameter int   C_depth             = 2
) (
    input  logic                clk_pixel,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                test_picture,
    input  logic [C_depth-1:0]  in_red,
    input  logic [C_depth-1:0]  in_green,
    input  logic [C_depth-1:0]  in_blue,
    output logic [C_bits_x-1:0] fetch_x,
    output logic [C_bits_y-1:0] fetch_y,
    output logic                fetch_valid,
    output logic                line_start,
    output logic                frame_start,
    output logic [7:0]          frame_count,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_blank,
    output logic [C_depth-1:0]  vga_red,
    output logic [C_depth-1:0]  vga_green,
    output logic [C_depth-1:0]  vga_blue
);

    localparam int H_TOTAL = h_total(C_resolution_x, C_hsync_front_porch, C_hsync_pulse, C_hsync_back_porch);
    localparam int V_TOTAL = v_total(C_resolution_y, C_vsync_front_porch, C_vsync_pulse, C_vsync_back_porch);
    localparam int HS_START = C_resolution_x + C_hsync_front_porch;
    localparam int VS_START = C_resolution_y + C_vsync_front_porch;
    localparam int LINE_W = 3 + C_bits_x + C_bits_y;
    localparam logic [LINE_W-1:0] LINE_RESET = {1'b1, 2'b00, {C_bits_x{1'b0}}, {C_bits_y{1'b0}}};

    generate
        if (!fits_width(C_bits_x, H_TOTAL - 1)) begin : g_bad_bits_x
            $error("vga_timing_gen: C_bits_x too narrow for H_total-1");
        end
        if (!fits_width(C_bits_y, V_TOTAL - 1)) begin : g_bad_bits_y
            $error("vga_timing_gen: C_bits_y too narrow for V_total-1");
        end
        if (C_fetch_lead < 1 || C_fetch_lead > 16) begin : g_bad_lead
            $error("vga_timing_gen: C_fetch_lead must be 1..16");
        end
        if (C_depth < 1 || C_depth > 8) begin : g_bad_depth
            $error("vga_timing_gen: C_depth must be 1..8");
        end
        if (C_hsync_pulse < 1 || C_vsync_pulse < 1) begin : g_bad_pulse
            $error("vga_timing_gen: sync pulses must be at least one unit wide");
        end
    endgenerate

    logic [C_bits_x-1:0] x;
    logic [C_bits_y-1:0] y;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
        end else if (enable) begin
            if (x == C_bits_x'(H_TOTAL - 1)) begin
                x <= '0;
                if (y == C_bits_y'(V_TOTAL - 1)) begin
                    y           <= '0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    y <= y + C_bits_y'(1);
                end
            end else begin
                x <= x + C_bits_x'(1);
            end
        end
    end

    logic x_active, y_active;
    logic raw_blank, raw_hs, raw_vs;

    assign x_active  = int'(x) < C_resolution_x;
    assign y_active  = int'(y) < C_resolution_y;
    assign raw_blank = !(x_active && y_active);
    assign raw_hs    = in_window(int'(x), HS_START, C_hsync_pulse);
    assign raw_vs    = in_window(int'(y), VS_START, C_vsync_pulse);

    assign fetch_x     = x;
    assign fetch_y     = y;
    assign fetch_valid = x_active && y_active;
    // Pulses are gated by rst_n so they stay low while reset holds the counters at the origin.
    assign line_start  = rst_n && enable && (x == '0) && y_active;
    assign frame_start = rst_n && enable && (x == '0) && (y == '0);

    logic                d_blank, d_hs, d_vs;
    logic [C_bits_x-1:0] d_x;
    logic [C_bits_y-1:0] d_y;

    video_delay_line #(
        .WIDTH       (LINE_W),
        .DEPTH       (C_fetch_lead - 1),
        .RESET_VALUE (LINE_RESET)
    ) u_delay (
        .clk   (clk_pixel),
        .rst_n (rst_n),
        .ce    (enable),
        .d     ({raw_blank, raw_hs, raw_vs, x, y}),
        .q     ({d_blank, d_hs, d_vs, d_x, d_y})
    );

    logic [C_depth-1:0] pat_red, pat_green, pat_blue;

    assign pat_red   = C_depth'(d_x >> 4);
    assign pat_green = C_depth'(d_y >> 4);
    assign pat_blue  = frame_count[C_depth-1:0];

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            vga_blank <= 1'b1;
            vga_hsync <= ~C_hsync_polarity;
            vga_vsync <= ~C_vsync_polarity;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else if (enable) begin
            vga_blank <= d_blank;
            vga_hsync <= d_hs ? C_hsync_polarity : ~C_hsync_polarity;
            vga_vsync <= d_vs ? C_vsync_polarity : ~C_vsync_polarity;
            if (d_blank) begin
                vga_red   <= '0;
                vga_green <= '0;
                vga_blue  <= '0;
            end else if (test_picture) begin
                vga_red   <= pat_red;
                vga_green <= pat_green;
                vga_blue  <= pat_blue;
            end else begin
                vga_red   <= in_red;
                vga_green <= in_green;
                vga_blue  <= in_blue;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a small raster mode, checked against a
// position-arithmetic reference model.
module tb_vga_timing_gen;

    localparam int RX = 8, HFP = 2, HP = 3, HBP = 1;
    localparam int RY = 4, VFP = 1, VP = 1, VBP = 1;
    localparam int H = RX + HFP + HP + HBP;
    localparam int V = RY + VFP + VP + VBP;
    localparam int HV = H * V;
    localparam int LEAD = 2;
    localparam int DEPTH = 2;
    localparam int BX = 5, BY = 4;

    logic             clk_pixel = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             test_picture = 1'b0;
    logic [DEPTH-1:0] in_red, in_green, in_blue;
    logic [BX-1:0]    fetch_x;
    logic [BY-1:0]    fetch_y;
    logic             fetch_valid, line_start, frame_start;
    logic [7:0]       frame_count;
    logic             vga_hsync, vga_vsync, vga_blank;
    logic [DEPTH-1:0] vga_red, vga_green, vga_blue;

    vga_timing_gen #(
        .C_resolution_x(RX), .C_hsync_front_porch(HFP), .C_hsync_pulse(HP), .C_hsync_back_porch(HBP),
        .C_resolution_y(RY), .C_vsync_front_porch(VFP), .C_vsync_pulse(VP), .C_vsync_back_porch(VBP),
        .C_bits_x(BX), .C_bits_y(BY), .C_hsync_polarity(1'b0), .C_vsync_polarity(1'b0),
        .C_fetch_lead(LEAD), .C_depth(DEPTH)
    ) dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable), .test_picture(test_picture),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid),
        .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Framebuffer stand-in with one cycle of read latency, so data for a fetch arrives in
    // time for the output register that displays it.
    always @(posedge clk_pixel) begin
        if (enable) begin
            in_red   <= fetch_x[1:0];
            in_green <= fetch_y[1:0];
            in_blue  <= fetch_x[1:0] ^ fetch_y[1:0];
        end
    end

    typedef struct {
        int fx, fy, valid, ls, fs, fc;
        int blank, hs, vs, r, g, b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_count = 0;
    bit   tp_last = 1'b0;
    bit   tp_cur = 1'b0;

    function automatic exp_t model(input int n, input bit en, input bit tp, input bit out_of_reset);
        exp_t e;
        int p, q, qx, qy;
        e = '{fx: 0, fy: 0, valid: 1, ls: 0, fs: 0, fc: 0, blank: 1, hs: 1, vs: 1, r: 0, g: 0, b: 0};
        if (!out_of_reset)
            return e;
        p = n % HV;
        e.fx    = p % H;
        e.fy    = p / H;
        e.fc    = (n / HV) % 256;
        e.valid = (e.fx < RX && e.fy < RY) ? 1 : 0;
        e.ls    = (en && e.fx == 0 && e.fy < RY) ? 1 : 0;
        e.fs    = (en && p == 0) ? 1 : 0;
        if (n >= LEAD) begin
            q  = n - LEAD;
            qx = q % H;
            qy = (q / H) % V;
            e.blank = (qx < RX && qy < RY) ? 0 : 1;
            e.hs    = (qx >= RX + HFP && qx < RX + HFP + HP) ? 0 : 1;
            e.vs    = (qy >= RY + VFP && qy < RY + VFP + VP) ? 0 : 1;
            if (e.blank == 0) begin
                if (tp) begin
                    e.r = (qx >> 4) & 3;
                    e.g = (qy >> 4) & 3;
                    e.b = ((q / HV) % 256) & 3;
                end else begin
                    e.r = qx & 3;
                    e.g = qy & 3;
                    e.b = (qx ^ qy) & 3;
                end
            end
        end
        return e;
    endfunction

    task automatic check_output(input string name, input int actual, input int required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, required);
        end
    endtask

    // Each cycle: account for the edge just taken, drive new inputs, queue the expected response.
    task automatic apply_stimulus(input bit en, input bit tp, input bit rst_release);
        @(posedge clk_pixel);
        if (!rst_n)
            edge_count = 0;
        else if (enable) begin
            edge_count++;
            tp_last = test_picture;
        end
        #1;
        rst_n        = rst_release;
        enable       = en;
        test_picture = tp;
        tp_cur       = tp;
        if (!rst_release)
            edge_count = 0;
        exp_q.push_back(model(edge_count, en, tp_last, rst_release));
    endtask

    task automatic run_to(input int tx, input int ty);
        for (int i = 0; i < 2 * HV; i++) begin
            if ((edge_count % HV) == ty * H + tx)
                break;
            apply_stimulus(1'b1, tp_cur, 1'b1);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest queued expectation.
    always @(negedge clk_pixel) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("fetch_x", int'(fetch_x), e.fx);
            check_output("fetch_y", int'(fetch_y), e.fy);
            check_output("fetch_valid", int'(fetch_valid), e.valid);
            check_output("line_start", int'(line_start), e.ls);
            check_output("frame_start", int'(frame_start), e.fs);
            check_output("frame_count", int'(frame_count), e.fc);
            check_output("vga_blank", int'(vga_blank), e.blank);
            check_output("vga_hsync", int'(vga_hsync), e.hs);
            check_output("vga_vsync", int'(vga_vsync), e.vs);
            check_output("vga_red", int'(vga_red), e.r);
            check_output("vga_green", int'(vga_green), e.g);
            check_output("vga_blue", int'(vga_blue), e.b);
        end
    end

    initial begin
        $display("[TB] start: H_total=%0d V_total=%0d lead=%0d", H, V, LEAD);

        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < HV + 20; i++)
            apply_stimulus(1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            apply_stimulus($urandom_range(0, 3) != 0, 1'b0, 1'b1);

        run_to(3, 1);
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++)
            apply_stimulus(1'b1, 1'b0, 1'b1);

        run_to(5, 2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < HV + 10; i++)
            apply_stimulus(1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0)
                tp_cur = ~tp_cur;
            apply_stimulus($urandom_range(0, 4) != 0, tp_cur, 1'b1);
        end

        for (int i = 0; i < 256 * HV + 2 * H; i++)
            apply_stimulus(1'b1, 1'b1, 1'b1);

        @(posedge clk_pixel);
        @(negedge clk_pixel);
        #1;
        check_output("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
